// File: rtl/alu_pkg.sv
// Shared ALU codes, RV32I opcodes and the ID/EX register record.
// Also holds the funct3 -> ALU code helpers used by the decoder.
package alu_pkg;

  localparam int ALU_CODE_W = 5;

  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_SUB      = 5'b00001;
  localparam logic [4:0] ALU_AND      = 5'b00010;
  localparam logic [4:0] ALU_OR       = 5'b00011;
  localparam logic [4:0] ALU_XOR      = 5'b00110;
  localparam logic [4:0] ALU_PASS_OP2 = 5'b01000;
  localparam logic [4:0] ALU_SRL      = 5'b01010;
  localparam logic [4:0] ALU_SRA      = 5'b01011;
  localparam logic [4:0] ALU_SLL      = 5'b01101;
  localparam logic [4:0] ALU_BEQ      = 5'b10000;
  localparam logic [4:0] ALU_BNE      = 5'b10001;
  localparam logic [4:0] ALU_BLT      = 5'b10010;
  localparam logic [4:0] ALU_BGE      = 5'b10011;
  localparam logic [4:0] ALU_BLTU     = 5'b10100;
  localparam logic [4:0] ALU_BGEU     = 5'b10101;
  localparam logic [4:0] ALU_SLT      = 5'b10110;
  localparam logic [4:0] ALU_SLTU     = 5'b10111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_ENC = 32'h00000013;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           instr;
    logic [ALU_CODE_W-1:0] alu_op;
    logic [31:0]           operand1;
    logic [31:0]           operand2;
    logic [31:0]           store_data;
    logic [31:0]           branch_target;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  is_branch;
    logic                  is_jump;
    logic                  illegal;
  } ex_ctrl_t;

  // alt selects SUB (f3=0) or SRA (f3=5); caller qualifies it per opcode
  function automatic logic [ALU_CODE_W-1:0] arith_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    arith_code = alt ? ALU_SUB : ALU_ADD;
      3'd1:    arith_code = ALU_SLL;
      3'd2:    arith_code = ALU_SLT;
      3'd3:    arith_code = ALU_SLTU;
      3'd4:    arith_code = ALU_XOR;
      3'd5:    arith_code = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arith_code = ALU_OR;
      default: arith_code = ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_CODE_W-1:0] branch_code(input logic [2:0] f3);
    case (f3)
      3'd0:    branch_code = ALU_BEQ;
      3'd1:    branch_code = ALU_BNE;
      3'd4:    branch_code = ALU_BLT;
      3'd5:    branch_code = ALU_BGE;
      3'd6:    branch_code = ALU_BLTU;
      default: branch_code = ALU_BGEU;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode into ALU code, operands, branch target and EX control flags.
// Zero latency; no flow control, the ID/EX register above handles stall and flush.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output ex_ctrl_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill;
  ex_ctrl_t    d;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    d          = '0;
    d.valid    = 1'b1;
    d.instr    = instr;
    d.rd       = instr[11:7];
    d.funct3   = f3;
    d.alu_op   = ALU_ADD;
    ill        = 1'b0;
    case (opcode)
      OPC_OP: begin
        d.operand1  = rs1_data;
        d.operand2  = rs2_data;
        d.reg_write = 1'b1;
        d.alu_op    = arith_code(f3, f7[5]);
        if (f3 == 3'd1 || f3 == 3'd5) d.operand2 = {27'b0, rs2_data[4:0]};
        if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        else if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
      end
      OPC_OP_IMM: begin
        d.operand1  = rs1_data;
        d.operand2  = imm_i;
        d.reg_write = 1'b1;
        d.alu_op    = arith_code(f3, f7[5] && f3 == 3'd5);
        if (f3 == 3'd1 || f3 == 3'd5) d.operand2 = {27'b0, instr[24:20]};
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
      end
      OPC_LUI: begin
        d.alu_op    = ALU_PASS_OP2;
        d.operand2  = imm_u;
        d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d.operand1  = pc;
        d.operand2  = imm_u;
        d.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        d.operand1  = rs1_data;
        d.operand2  = imm_i;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ill = 1'b1;
      end
      OPC_STORE: begin
        d.operand1   = rs1_data;
        d.operand2   = imm_s;
        d.mem_write  = 1'b1;
        d.store_data = rs2_data;
        if (f3 > 3'd2) ill = 1'b1;
      end
      OPC_BRANCH: begin
        d.alu_op        = branch_code(f3);
        d.operand1      = rs1_data;
        d.operand2      = rs2_data;
        d.branch_target = pc + imm_b;
        d.is_branch     = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      end
      OPC_JAL: begin
        d.operand1      = pc;
        d.operand2      = 32'd4;
        d.branch_target = pc + imm_j;
        d.is_jump       = 1'b1;
        d.reg_write     = 1'b1;
      end
      OPC_JALR: begin
        d.operand1      = pc;
        d.operand2      = 32'd4;
        d.branch_target = (rs1_data + imm_i) & ~32'd1;
        d.is_jump       = 1'b1;
        d.reg_write     = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    // Illegal keeps identity fields only; EX must not act on any of the rest
    dec = d;
    if (ill) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.instr   = instr;
      dec.rd      = d.rd;
      dec.funct3  = f3;
      dec.alu_op  = ALU_ADD;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID-stage ALU control plus ID/EX register; 1-cycle latency, 1 instr/cycle.
// Priority rst > flush > stall > load; stall holds, flush or empty ID loads a bubble.
module id_ex_alu_ctrl
  import alu_pkg::*;
#(
  parameter int          ALU_OP_W  = 5,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_rs1_data,
  input  logic [31:0]         id_rs2_data,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [31:0]         ex_instr,
  output logic [ALU_OP_W-1:0] ex_alu_operation,
  output logic [31:0]         ex_operand1,
  output logic [31:0]         ex_operand2,
  output logic [31:0]         ex_store_data,
  output logic [31:0]         ex_branch_target,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_is_branch,
  output logic                ex_is_jump,
  output logic                ex_illegal,
  output logic [2:0]          ex_funct3
);

  ex_ctrl_t dec, bubble, ex_d, ex_q;

  alu_ctrl_decode u_decode (
    .instr    (id_instr),
    .pc       (id_pc),
    .rs1_data (id_rs1_data),
    .rs2_data (id_rs2_data),
    .dec      (dec)
  );

  always_comb begin
    bubble       = '0;
    bubble.instr = NOP_INSTR;
    bubble.alu_op = ALU_ADD;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush || (!stall && !id_valid)) ex_d = bubble;
    else if (!stall)                    ex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= bubble;
    else     ex_q <= ex_d;
  end

  assign ex_valid         = ex_q.valid;
  assign ex_instr         = ex_q.instr;
  assign ex_alu_operation = ALU_OP_W'(ex_q.alu_op);
  assign ex_operand1      = ex_q.operand1;
  assign ex_operand2      = ex_q.operand2;
  assign ex_store_data    = ex_q.store_data;
  assign ex_branch_target = ex_q.branch_target;
  assign ex_rd            = ex_q.rd;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_is_branch     = ex_q.is_branch;
  assign ex_is_jump       = ex_q.is_jump;
  assign ex_illegal       = ex_q.illegal;
  assign ex_funct3        = ex_q.funct3;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Scoreboarded bench for id_ex_alu_ctrl using hand-derived expected records.
module tb_id_ex_alu_ctrl;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] sd;
    logic [31:0] tg;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [5:0]  fl;  // {reg_write, mem_read, mem_write, is_branch, is_jump, illegal}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal;
  logic [31:0] ex_instr, ex_operand1, ex_operand2, ex_store_data, ex_branch_target;
  logic [4:0]  ex_alu_operation, ex_rd;
  logic [2:0]  ex_funct3;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t bub, e_jalr;

  always #5 clk = ~clk;

  id_ex_alu_ctrl #(.ALU_OP_W(5), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_alu_operation(ex_alu_operation),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_store_data(ex_store_data),
    .ex_branch_target(ex_branch_target), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal), .ex_funct3(ex_funct3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] ins, input logic [4:0] op,
                              input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] sd,
                              input logic [31:0] tg, input logic [4:0] rd, input logic [2:0] f3,
                              input logic [5:0] fl);
    exp_t e;
    e.valid = v; e.instr = ins; e.op = op; e.o1 = o1; e.o2 = o2;
    e.sd = sd; e.tg = tg; e.rd = rd; e.f3 = f3; e.fl = fl;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "/valid"}, 32'(ex_valid), 32'(e.valid));
    chk({tag, "/instr"}, ex_instr, e.instr);
    chk({tag, "/alu_op"}, 32'(ex_alu_operation), 32'(e.op));
    chk({tag, "/op1"}, ex_operand1, e.o1);
    chk({tag, "/op2"}, ex_operand2, e.o2);
    chk({tag, "/store"}, ex_store_data, e.sd);
    chk({tag, "/target"}, ex_branch_target, e.tg);
    chk({tag, "/rd"}, 32'(ex_rd), 32'(e.rd));
    chk({tag, "/funct3"}, 32'(ex_funct3), 32'(e.f3));
    chk({tag, "/flags"},
        32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal}),
        32'(e.fl));
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b, input logic st, input logic fl,
                      input logic r, input exp_t e);
    @(negedge clk);
    id_valid = v; id_instr = ins; id_pc = pc; id_rs1_data = a; id_rs2_data = b;
    stall = st; flush = fl; rst = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bub = mk(1'b0, 32'h00000013, 5'b00000, 0, 0, 0, 0, 5'd0, 3'd0, 6'b000000);
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; id_pc = 32'h0;
    id_rs1_data = 32'h0; id_rs2_data = 32'h0; stall = 1'b0; flush = 1'b0;
    step("reset", 1'b1, 32'h00208033, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1, bub);

    step("addi", 1'b1, 32'hFFD08293, 32'h0, 32'd10, 32'h0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'hFFD08293, 5'b00000, 32'd10, 32'hFFFFFFFD, 0, 0, 5'd5, 3'd0, 6'b100000));
    step("sub", 1'b1, 32'h402081B3, 32'h0, 32'd7, 32'd5, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h402081B3, 5'b00001, 32'd7, 32'd5, 0, 0, 5'd3, 3'd0, 6'b100000));
    step("sra", 1'b1, 32'h4020D233, 32'h0, 32'h80000000, 32'h00000124, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h4020D233, 5'b01011, 32'h80000000, 32'h4, 0, 0, 5'd4, 3'd5, 6'b100000));
    step("blt", 1'b1, 32'h0020C463, 32'h100, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0020C463, 5'b10010, 32'd1, 32'd2, 0, 32'h108, 5'd8, 3'd4, 6'b000100));
    e_jalr = mk(1'b1, 32'h004100E7, 5'b00000, 32'h40, 32'd4, 0, 32'h2004, 5'd1, 3'd0, 6'b100010);
    step("jalr", 1'b1, 32'h004100E7, 32'h40, 32'h2001, 32'h2001, 1'b0, 1'b0, 1'b0, e_jalr);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 32'h00208033 + 32'(i << 7), 32'h80, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, e_jalr);
    step("stall_flush", 1'b1, 32'h00208033, 32'h80, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0, bub);

    step("illegal_ff", 1'b1, 32'hFFFFFFFF, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'hFFFFFFFF, 5'b00000, 0, 0, 0, 0, 5'd31, 3'd7, 6'b000001));
    step("add_x0", 1'b1, 32'h00208033, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h00208033, 5'b00000, 32'd3, 32'd4, 0, 0, 5'd0, 3'd0, 6'b000000));
    step("lui", 1'b1, 32'h123453B7, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h123453B7, 5'b01000, 0, 32'h12345000, 0, 0, 5'd7, 3'd5, 6'b100000));
    step("sw", 1'b1, 32'h0020A423, 32'h0, 32'h1000, 32'hDEAD, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0020A423, 5'b00000, 32'h1000, 32'd8, 32'hDEAD, 0, 5'd8, 3'd2, 6'b001000));
    step("id_invalid", 1'b0, 32'h0020A423, 32'h0, 32'h1000, 32'hDEAD, 1'b0, 1'b0, 1'b0, bub);
    step("br_f3_2", 1'b1, 32'h0020A463, 32'h100, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0020A463, 5'b00000, 0, 0, 0, 0, 5'd8, 3'd2, 6'b000001));
    step("slli_bad", 1'b1, 32'h40109093, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h40109093, 5'b00000, 0, 0, 0, 0, 5'd1, 3'd1, 6'b000001));
    step("auipc", 1'b1, 32'h00001097, 32'h200, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h00001097, 5'b00000, 32'h200, 32'h1000, 0, 0, 5'd1, 3'd1, 6'b100000));
    step("jal_back", 1'b1, 32'hFFDFF0EF, 32'h300, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'hFFDFF0EF, 5'b00000, 32'h300, 32'd4, 0, 32'h2FC, 5'd1, 3'd7, 6'b100010));
    step("flush_only", 1'b1, 32'h00208033, 32'h0, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, bub);
    step("rst_stall", 1'b1, 32'h00208033, 32'h0, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1, bub);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_ctrl.md
# id_ex_alu_ctrl

- ID-stage ALU control and ID/EX pipeline register of the pipelined RV32I core.
- Decodes each instruction into the 5-bit ALU operation code, selects both ALU operands, computes the branch/jump target, and registers everything for EX under stall/flush control.
- It drives the ALU's operation and operand inputs one cycle after decode.

## Interface
Parameters:
- ALU_OP_W, 5, width of ALU operation code
- NOP_INSTR, 32'h00000013, encoding reported in ex_instr for a bubble

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction word
- id_pc  in  32  instruction address
- id_rs1_data, id_rs2_data  in  32 each  register-file read data (already forwarded)
- stall  in  1  hold ID/EX contents
- flush  in  1  replace next ID/EX contents with a bubble
- ex_valid  out  1  EX slot holds a real instruction
- ex_instr  out  32  registered instruction (NOP_INSTR when bubble)
- ex_alu_operation  out  ALU_OP_W  ALU operation code
- ex_operand1, ex_operand2  out  32 each  ALU operands
- ex_store_data  out  32  rs2 data for stores
- ex_branch_target  out  32  target for branches/JAL/JALR
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal  out  1 each  control flags
- ex_funct3  out  3  load/store size field

## Operation
ALU codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00110, PASS_OP2 01000, SRL 01010, SRA 01011, SLL 01101, BEQ 10000, BNE 10001, BLT 10010, BGE 10011, BLTU 10100, BGEU 10101, SLT 10110, SLTU 10111.

Instruction mapping:
- OP / OP-IMM: funct3/funct7 select the code.
  - funct7[5] selects SUB only for OP, and SRA for both OP and OP-IMM.
  - operand1 = rs1.
  - operand2 = rs2 (OP) or sign-extended I-immediate (OP-IMM).
- Shifts: operand2 = {27'b0, shamt}, where shamt = rs2[4:0] or imm[4:0]. This is mandatory because the ALU shifts by the full 32-bit operand.
- LUI: PASS_OP2, operand2 = U-immediate.
- AUIPC: ADD, operand1 = pc, operand2 = U-immediate.
- LOAD / STORE: ADD, operand1 = rs1, operand2 = I- or S-immediate.
  - mem_read / mem_write asserted; store_data = rs2.
- BRANCH: code from funct3 (BEQ…BGEU), operand1 = rs1, operand2 = rs2, target = pc + B-immediate, is_branch = 1.
- JAL: ADD, operand1 = pc, operand2 = 4, target = pc + J-immediate, is_jump = 1.
- JALR: ADD, operand1 = pc, operand2 = 4, target = (rs1 + I-immediate) & ~1, is_jump = 1.
- reg_write = 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR. It is forced to 0 when rd == 0.
- Illegal instructions:
  - Triggers: undefined opcode, OP funct7 not in {0x00, 0x20}, funct7 0x20 with funct3 other than 0/5, OP-IMM shift with bad imm[11:5], branch funct3 2/3, load funct3 3/6/7, store funct3 > 2.
  - Result: ex_illegal = 1, ex_valid = 1, code ADD, all write/mem/branch/jump flags 0.
- All arithmetic is modulo 2^32. Immediates are sign-extended from their top bit.

## Timing
- Register update priority, highest first: rst > flush > stall > load.
- rst: all outputs 0, except ex_instr = NOP_INSTR.
- flush, or id_valid = 0 with no stall: load a bubble.
  - Bubble: ex_valid = 0, all flags 0, code ADD, operands 0, ex_instr = NOP_INSTR.
- flush with stall in the same cycle: the bubble wins.
- stall alone: all outputs hold their previous values.
- Otherwise: decoded outputs appear the cycle after the ID inputs are sampled. Latency is 1 cycle, throughput 1 per cycle.
- Decode is purely combinational from the ID inputs. There is no internal state besides the register.
- Reset asserted mid-stall clears the register on the same edge.

## Structure
- Package alu_pkg holds:
  - ALU code localparams (shared with the ALU)
  - RV32I opcode localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR)
  - NOP encoding
- Sub-module alu_ctrl_decode: combinational instruction → control/operand/target decode.
- Top id_ex_alu_ctrl: instantiates alu_ctrl_decode plus the prioritized ID/EX register.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), rs1 = 10 → next cycle: code 00000, op1 10, op2 0xFFFFFFFD, rd 5, reg_write 1, valid 1.
- SUB x3,x1,x2 (0x402081B3) → code 00001. SRA x4,x1,x2 (0x4020D233) with rs2 = 0x00000124 → code 01011, op2 0x00000004.
- BLT x1,x2,+8 (0x0020C463) at pc 0x100 → code 10010, is_branch 1, target 0x108, reg_write 0.
- JALR x1,4(x2) with rs2/rs1 = 0x2001, pc 0x40 → op1 0x40, op2 4, target 0x2004, is_jump 1.
- Stall held for 3 cycles with changing id_instr → outputs unchanged. Then stall + flush → bubble (valid 0, ex_instr 0x00000013).
- 0xFFFFFFFF → ex_illegal 1, valid 1, all write/mem flags 0. ADD x0,x1,x2 → reg_write 0.
